// File: rtl/queue_ingress_rr_arbiter.sv
// Packet-atomic round-robin merge of NUM_PORTS AXI-Stream sources; one cycle to arbitrate from idle,
// zero-latency pass-through once granted. Downstream ready is steered only to the granted port.
`timescale 1ns/1ps
module queue_ingress_rr_arbiter #(
  parameter int NUM_PORTS         = 4,
  parameter int AXIS_DATA_WIDTH   = 64,
  parameter int PACKET_SIZE_WIDTH = 11,
  parameter int PORT_ID_WIDTH     = $clog2(NUM_PORTS),
  parameter int PKT_CNT_WIDTH     = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_PORTS-1:0]                   s_axis_tvalid_i,
  output logic [NUM_PORTS-1:0]                   s_axis_tready_o,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0]   s_axis_tdata_i,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep_i,
  input  logic [NUM_PORTS-1:0]                   s_axis_tlast_i,
  input  logic [NUM_PORTS*PACKET_SIZE_WIDTH-1:0] s_axis_packet_length_i,
  input  logic                                   m_axis_tready_i,
  output logic                                   m_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0]             m_axis_tdata_o,
  output logic [AXIS_DATA_WIDTH/8-1:0]           m_axis_tkeep_o,
  output logic                                   m_axis_tlast_o,
  output logic [PACKET_SIZE_WIDTH-1:0]           m_axis_packet_length_o,
  output logic [PORT_ID_WIDTH-1:0]               m_port_id_o,
  output logic [PKT_CNT_WIDTH-1:0]               pkt_count_o
);

  localparam int KEEP_WIDTH = AXIS_DATA_WIDTH / 8;

  typedef enum logic {IDLE, PASS} state_t;

  state_t                   state;
  logic [PORT_ID_WIDTH-1:0] grant;
  logic [PORT_ID_WIDTH-1:0] last_grant;
  logic [PKT_CNT_WIDTH-1:0] pkt_count;

  logic [AXIS_DATA_WIDTH-1:0]   tdata_a [NUM_PORTS];
  logic [KEEP_WIDTH-1:0]        tkeep_a [NUM_PORTS];
  logic [PACKET_SIZE_WIDTH-1:0] len_a   [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_slice
    assign tdata_a[p] = s_axis_tdata_i[p*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    assign tkeep_a[p] = s_axis_tkeep_i[p*KEEP_WIDTH +: KEEP_WIDTH];
    assign len_a[p]   = s_axis_packet_length_i[p*PACKET_SIZE_WIDTH +: PACKET_SIZE_WIDTH];
  end

  // Returns {found, index}; candidates start at base+1 and wrap around to base itself.
  function automatic logic [PORT_ID_WIDTH:0] rr_pick(input logic [NUM_PORTS-1:0]     req,
                                                     input logic [PORT_ID_WIDTH-1:0] base);
    logic [PORT_ID_WIDTH:0]   res;
    logic [PORT_ID_WIDTH-1:0] sel;
    res = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      sel = PORT_ID_WIDTH'((int'(base) + k) % NUM_PORTS);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  logic [NUM_PORTS-1:0]   grant_onehot;
  logic [PORT_ID_WIDTH:0] idle_pick;
  logic [PORT_ID_WIDTH:0] end_pick;
  logic                   pkt_end;

  assign grant_onehot = NUM_PORTS'(1) << grant;
  assign idle_pick    = rr_pick(s_axis_tvalid_i, last_grant);
  // The finishing port's tlast beat is not a new request, so it is masked out of the re-search.
  assign end_pick     = rr_pick(s_axis_tvalid_i & ~grant_onehot, grant);
  assign pkt_end      = (state == PASS) && s_axis_tvalid_i[grant] && m_axis_tready_i
                        && s_axis_tlast_i[grant];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= PORT_ID_WIDTH'(NUM_PORTS - 1);
      pkt_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[PORT_ID_WIDTH]) begin
            grant <= idle_pick[PORT_ID_WIDTH-1:0];
            state <= PASS;
          end
        end
        PASS: begin
          if (pkt_end) begin
            last_grant <= grant;
            pkt_count  <= pkt_count + 1'b1;
            if (end_pick[PORT_ID_WIDTH]) begin
              grant <= end_pick[PORT_ID_WIDTH-1:0];
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_axis_tready_o = '0;
    if (state == PASS) s_axis_tready_o[grant] = m_axis_tready_i;
  end

  assign m_axis_tvalid_o        = (state == PASS) && s_axis_tvalid_i[grant];
  assign m_axis_tdata_o         = tdata_a[grant];
  assign m_axis_tkeep_o         = tkeep_a[grant];
  assign m_axis_tlast_o         = s_axis_tlast_i[grant];
  assign m_axis_packet_length_o = len_a[grant];
  assign m_port_id_o            = grant;
  assign pkt_count_o            = pkt_count;

endmodule
